// File: rtl/gate_stim_pkg.sv
// rtl/gate_stim_pkg.sv - shared types and sizing helpers for the gate stimulus sequencer
package gate_stim_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef enum logic {
    PH_A = 1'b0,
    PH_B = 1'b1
  } phase_t;

  // Interleaved sweep (0,0),(1,0),(1,1)...(max,max) has 2**(w+1)-1 vectors
  function automatic int num_vectors(input int width);
    return (2 ** (width + 1)) - 1;
  endfunction

  // Bits needed to hold a vector index for a given operand width
  function automatic int idx_width(input int width);
    return $clog2(2 ** (width + 1));
  endfunction

endpackage

// File: rtl/gate_stim_seq_settle_timer.sv
// rtl/gate_stim_seq_settle_timer.sv - loadable down-counter with zero flag for settle dwell
module settle_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  output logic          o_zero
);

  logic [CW-1:0] r_count;

  // Load has priority; decrement stops at zero so the flag stays asserted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/gate_stim_seq.sv
// rtl/gate_stim_seq.sv - operand sweep sequencer with settle dwell and valid/ready output
module gate_stim_seq
  import gate_stim_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DWELL = 10
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               a,
  output logic [WIDTH-1:0]               b,
  output logic                           out_valid,
  output logic [idx_width(WIDTH)-1:0]    vec_idx,
  output logic                           busy,
  output logic                           done
);

  localparam int IW = idx_width(WIDTH);
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(DWELL - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(num_vectors(WIDTH) - 1);

  state_t           r_state;
  state_t           w_next_state;
  phase_t           r_phase;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IW-1:0]    r_idx;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  logic w_load;
  logic w_dec;
  logic w_zero;
  logic w_begin;
  logic w_advance;

  settle_timer #(.CW(CW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  // State register plus flag outputs registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_valid <= (w_next_state == PRESENT);
      r_busy  <= (w_next_state == SETTLE) || (w_next_state == PRESENT);
      r_done  <= (w_next_state == DONE);
    end
  end

  // Next-state decode: start only honoured when not busy; accept either finishes or advances
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    w_begin      = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_next_state = SETTLE;
          w_load       = 1'b1;
          w_begin      = 1'b1;
        end
      end
      SETTLE: begin
        if (w_zero) begin
          w_next_state = PRESENT;
        end else begin
          w_dec = 1'b1;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          if (r_idx == LAST_IDX) begin
            w_next_state = DONE;
          end else begin
            w_next_state = SETTLE;
            w_load       = 1'b1;
            w_advance    = 1'b1;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Operand registers: clear on sweep start, step a then b alternately on each accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_phase <= PH_A;
    end else if (w_begin) begin
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_phase <= PH_A;
    end else if (w_advance) begin
      r_idx <= r_idx + IW'(1);
      if (r_phase == PH_A) begin
        r_a     <= r_a + WIDTH'(1);
        r_phase <= PH_B;
      end else begin
        r_b     <= r_b + WIDTH'(1);
        r_phase <= PH_A;
      end
    end
  end

  assign a         = r_a;
  assign b         = r_b;
  assign vec_idx   = r_idx;
  assign out_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_gate_stim_seq.sv
// tb/tb_gate_stim_seq.sv - self-checking bench for gate_stim_seq (DWELL=10 and DWELL=1 instances)
module tb_gate_stim_seq;

  localparam int NV = 31;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: DWELL=10
  logic       rst0, start0, ready0;
  logic [3:0] a0, b0;
  logic [4:0] idx0;
  logic       vld0, busy0, done0;

  // Instance 1: DWELL=1
  logic       rst1, start1, ready1;
  logic [3:0] a1, b1;
  logic [4:0] idx1;
  logic       vld1, busy1, done1;

  gate_stim_seq #(.WIDTH(4), .DWELL(10)) dut0 (
    .clk(clk), .reset(rst0), .start(start0), .out_ready(ready0),
    .a(a0), .b(b0), .out_valid(vld0), .vec_idx(idx0), .busy(busy0), .done(done0)
  );

  gate_stim_seq #(.WIDTH(4), .DWELL(1)) dut1 (
    .clk(clk), .reset(rst1), .start(start1), .out_ready(ready1),
    .a(a1), .b(b1), .out_valid(vld1), .vec_idx(idx1), .busy(busy1), .done(done1)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sweep model: vector k shows a=(k+1)/2, b=k/2; offered once it has been visible DWELL cycles
  int mk0 = 0, mage0 = 0, mk1 = 0, mage1 = 0;
  bit mact0 = 0, mdone0 = 0, mact1 = 0, mdone1 = 0;

  task automatic model_step(input int dw, input bit rst, input bit st, input bit rdy,
                            inout int k, inout int age, inout bit act, inout bit dn);
    if (rst) begin
      k = 0; age = 0; act = 0; dn = 0;
    end else if (!act) begin
      if (st) begin
        k = 0; age = 0; act = 1; dn = 0;
      end
    end else if (age >= dw && rdy) begin
      if (k == NV - 1) begin
        act = 0; dn = 1;
      end else begin
        k = k + 1; age = 0;
      end
    end else begin
      age = age + 1;
    end
  endtask

  function automatic logic [31:0] exp_pack(input int dw, input int k, input int age,
                                           input bit act, input bit dn);
    logic [3:0] ea, eb;
    logic [4:0] ei;
    ea = 4'((k + 1) / 2);
    eb = 4'(k / 2);
    ei = 5'(k);
    return {16'd0, ea, eb, ei, (act && age >= dw), act, dn};
  endfunction

  always @(posedge clk or posedge rst0)
    model_step(10, rst0, start0, ready0, mk0, mage0, mact0, mdone0);

  always @(posedge clk or posedge rst1)
    model_step(1, rst1, start1, ready1, mk1, mage1, mact1, mdone1);

  // Every cycle, both instances must match the model
  always @(negedge clk) begin
    chk("model_dwell10", {16'd0, a0, b0, idx0, vld0, busy0, done0},
        exp_pack(10, mk0, mage0, mact0, mdone0));
    chk("model_dwell1", {16'd0, a1, b1, idx1, vld1, busy1, done1},
        exp_pack(1, mk1, mage1, mact1, mdone1));
  end

  // Pulse start on dut0 and check first vector timing (valid 11 cycles after start edge)
  task automatic start_sweep0(input string tag);
    int n;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk({tag, "_restart_outputs"}, {27'd0, a0, b0, done0, busy0}, 32'b0000_0000_0_1);
    n = 1;
    while (!vld0 && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_first_valid_cycle"}, n, 11);
    chk({tag, "_first_vector"}, {19'd0, a0, b0, idx0}, 32'd0);
  endtask

  // Accept vectors on dut0 until done (or reset injection); optional backpressure/start stress
  task automatic sweep0(input string tag, input bit inject, input int rst_idx, output int acc);
    int guard, last_acc, acc5;
    bit bp_done, s1, s2, seen6;
    acc = 0; guard = 0; last_acc = 0; acc5 = 0;
    bp_done = 0; s1 = 0; s2 = 0; seen6 = 0;
    ready0 = 1'b1;
    while (!done0 && guard < 3000) begin
      start0 = 1'b0;
      if (rst_idx >= 0 && busy0 && !vld0 && idx0 == 5'(rst_idx)) begin
        #2 rst0 = 1'b1;
        #1 chk({tag, "_async_reset_outputs"}, {16'd0, a0, b0, idx0, vld0, busy0, done0}, 32'd0);
        return;
      end
      if (inject && vld0 && idx0 == 5'd5 && !bp_done) begin
        bp_done = 1;
        ready0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
          chk({tag, "_backpressure_hold"}, {22'd0, a0, b0, idx0, vld0}, {22'd0, 4'd3, 4'd2, 5'd5, 1'b1});
          tick();
        end
        ready0 = 1'b1;
      end
      if (inject && vld0 && idx0 == 5'd6 && !seen6) begin
        seen6 = 1;
        chk({tag, "_post_bp_latency"}, cyc - acc5, 11);
        chk({tag, "_post_bp_vector"}, {24'd0, a0, b0}, {24'd0, 4'd3, 4'd3});
      end
      if (inject && busy0 && !vld0 && idx0 == 5'd7 && !s1) begin
        s1 = 1; start0 = 1'b1;
      end else if (inject && vld0 && idx0 == 5'd7 && !s2) begin
        s2 = 1; start0 = 1'b1;
      end
      if (vld0 && ready0) begin
        acc++;
        last_acc = cyc;
        if (idx0 == 5'd5) acc5 = cyc;
      end
      tick();
      guard++;
    end
    start0 = 1'b0;
    chk({tag, "_done_latency"}, cyc - last_acc, 1);
    chk({tag, "_final_state"}, {16'd0, a0, b0, idx0, vld0, busy0, done0},
        {16'd0, 4'hF, 4'hF, 5'd30, 1'b0, 1'b0, 1'b1});
  endtask

  initial begin
    int acc;
    rst0 = 1'b1; start0 = 1'b0; ready0 = 1'b1;
    rst1 = 1'b1; start1 = 1'b0; ready1 = 1'b1;
    fork
      begin : proc_dwell10
        tick(); tick();
        chk("reset_state", {16'd0, a0, b0, idx0, vld0, busy0, done0}, 32'd0);
        rst0 = 1'b0;
        tick();
        // Sweep 1 with backpressure and ignored start pulses
        start_sweep0("s1");
        sweep0("s1", 1'b1, -1, acc);
        chk("s1_accepts", acc, NV);
        // Restart from DONE, full clean sweep
        start_sweep0("s2");
        sweep0("s2", 1'b0, -1, acc);
        chk("s2_accepts", acc, NV);
        // Sweep 3 aborted by reset mid-settle at vec_idx 12
        start_sweep0("s3");
        sweep0("s3", 1'b0, 12, acc);
        chk("s3_accepts_before_reset", acc, 12);
        tick(); tick();
        rst0 = 1'b0;
        for (int i = 0; i < 20; i++) begin
          tick();
          chk("idle_hold", {16'd0, a0, b0, idx0, vld0, busy0, done0}, 32'd0);
        end
        start_sweep0("s4");
        sweep0("s4", 1'b0, -1, acc);
        chk("s4_accepts", acc, NV);
      end
      begin : proc_dwell1
        int n, k;
        tick(); tick();
        rst1 = 1'b0;
        tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 1; k = 0;
        while (n <= 70) begin
          if (vld1) begin
            chk("d1_valid_cycle", n, 2 + 2 * k);
            chk("d1_vec_idx", {27'd0, idx1}, k);
            k++;
          end
          if (n == 62) chk("d1_last_vector", {23'd0, vld1, a1, b1}, {23'd0, 1'b1, 4'hF, 4'hF});
          if (n == 63) chk("d1_done", {30'd0, done1, busy1}, 32'b10);
          tick();
          n++;
        end
        chk("d1_vector_count", k, NV);
      end
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
